// File: rtl/seq110_pkg.sv
// ---------------------------------------------------------------------------
// seq110_pkg
// Shared types for the "110" scan controller and its embedded detector.
//   ctrl_state_t : controller phases (IDLE -> SHIFT -> REPORT)
//   det_state_t  : detector prefix states (S0 none, S1 "1", S2 "11")
//   DET_STATE_W  : width of the detector state encoding
// ---------------------------------------------------------------------------
package seq110_pkg;

  localparam int DET_STATE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } ctrl_state_t;

  typedef enum logic [DET_STATE_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } det_state_t;

endpackage

// File: rtl/det110_core.sv
// ---------------------------------------------------------------------------
// det110_core
// Non-overlapping "110" Mealy detector with step enable and synchronous
// clear.
//   clk    : clock
//   reset  : asynchronous active-low reset, forces S0
//   en     : step the detector on this edge
//   clr    : return to S0 on this edge (wins over en)
//   din    : serial input bit
//   hit    : Mealy output, high when a 0 arrives in S2 while enabled
//   state  : current detector state, for debug
// ---------------------------------------------------------------------------
module det110_core
  import seq110_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   din,
  output logic                   hit,
  output logic [DET_STATE_W-1:0] state
);

  det_state_t r_state;

  // Prefix tracker; after a hit it restarts from S0, so matches never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S0;
    end else if (clr) begin
      r_state <= S0;
    end else if (en) begin
      case (r_state)
        S0:      r_state <= din ? S1 : S0;
        S1:      r_state <= din ? S2 : S0;
        S2:      r_state <= din ? S2 : S0;
        default: r_state <= S0;
      endcase
    end
  end

  // Gated by en so the debug hit stays quiet outside the shift phase.
  assign hit   = en && (r_state == S2) && !din;
  assign state = r_state;

endmodule

// File: rtl/seq110_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seq110_scan_ctrl
// Accepts a word over valid/ready, shifts it MSB-first through det110_core,
// then offers the match count, last match position and any-flag over a
// valid/ready result port.
//   clk, reset            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input word handshake
//   in_data               : word to scan, MSB first
//   in_clear              : sampled with the handshake, clears the detector
//   out_valid/out_ready   : result handshake
//   out_count             : saturating number of detections in the word
//   out_last_pos          : bit index of the final 0 of the last detection
//   out_any               : at least one detection
//   det_state, det_hit    : detector debug view
// ---------------------------------------------------------------------------
module seq110_scan_ctrl
  import seq110_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int POS_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [POS_W-1:0]  out_last_pos,
  output logic              out_any,
  output logic [1:0]        det_state,
  output logic              det_hit
);

  ctrl_state_t       r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [POS_W-1:0]  r_bitCnt;
  logic [CNT_W-1:0]  r_count;
  logic [POS_W-1:0]  r_lastPos;
  logic              r_any;
  logic              r_inReady;
  logic              r_outValid;

  logic              w_accept;
  logic              w_shiftEn;
  logic              w_detClr;
  logic              w_hit;
  logic [DET_STATE_W-1:0] w_detState;

  assign w_accept  = (r_state == IDLE) && r_inReady && in_valid;
  assign w_shiftEn = (r_state == SHIFT);
  assign w_detClr  = w_accept && in_clear;

  det110_core u_det (
    .clk   (clk),
    .reset (reset),
    .en    (w_shiftEn),
    .clr   (w_detClr),
    .din   (r_shreg[WORD_W-1]),
    .hit   (w_hit),
    .state (w_detState)
  );

  // Controller. in_ready is a register so it stays low through reset and
  // rises on the first edge after release; out_valid mirrors REPORT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bitCnt   <= '0;
      r_count    <= '0;
      r_lastPos  <= '0;
      r_any      <= 1'b0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg   <= in_data;
            r_bitCnt  <= POS_W'(WORD_W - 1);
            r_count   <= '0;
            r_lastPos <= '0;
            r_any     <= 1'b0;
            r_inReady <= 1'b0;
            r_state   <= SHIFT;
          end else begin
            r_inReady <= 1'b1;
          end
        end
        SHIFT: begin
          r_shreg <= r_shreg << 1;
          if (w_hit) begin
            if (r_count != '1) begin
              r_count <= r_count + 1'b1;
            end
            r_lastPos <= r_bitCnt;
            r_any     <= 1'b1;
          end
          if (r_bitCnt == '0) begin
            r_outValid <= 1'b1;
            r_state    <= REPORT;
          end else begin
            r_bitCnt <= r_bitCnt - 1'b1;
          end
        end
        REPORT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_inReady;
  assign out_valid    = r_outValid;
  assign out_count    = r_count;
  assign out_last_pos = r_lastPos;
  assign out_any      = r_any;
  assign det_state    = w_detState;
  assign det_hit      = w_hit;

endmodule

// File: tb/tb_seq110_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq110_scan_ctrl
// Bench for seq110_scan_ctrl: a CNT_W=4 instance and a CNT_W=1 instance
// share all inputs so the saturating counter is exercised on every word.
// ---------------------------------------------------------------------------
module tb_seq110_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_clear = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_any, det_hit;
  logic [3:0] out_count;
  logic [2:0] out_last_pos;
  logic [1:0] det_state;

  logic       satInReady, satOutValid, satOutAny, satDetHit;
  logic [0:0] satOutCount;
  logic [2:0] satOutLastPos;
  logic [1:0] satDetState;

  int checks = 0;
  int failures = 0;

  // Model state: bits seen since the last clear, reset or detection.
  bit   histQ[$];
  int   mCount, mPos, mState;
  logic mAny;
  bit   mHits[8];

  typedef struct {
    logic [7:0] data;
    logic       clr;
    int         expCount;
    int         expPos;
    logic       expAny;
    int         expState;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  seq110_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_clear(in_clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_last_pos(out_last_pos),
    .out_any(out_any), .det_state(det_state), .det_hit(det_hit)
  );

  seq110_scan_ctrl #(.WORD_W(8), .CNT_W(1)) dutSat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(satInReady),
    .in_data(in_data), .in_clear(in_clear), .out_valid(satOutValid),
    .out_ready(out_ready), .out_count(satOutCount), .out_last_pos(satOutLastPos),
    .out_any(satOutAny), .det_state(satDetState), .det_hit(satDetHit)
  );

  // Single comparison point: every check goes through here.
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a detection is the pattern 1,1,0 at the tail of the bits
  // seen since the last restart; a detection restarts the history.
  task automatic modelWord(input logic [7:0] d, input logic clr);
    int sz;
    if (clr) histQ.delete();
    mCount = 0; mPos = 0; mAny = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      histQ.push_back(d[i]);
      mHits[i] = 1'b0;
      sz = histQ.size();
      if (sz >= 3 && histQ[sz-3] && histQ[sz-2] && !histQ[sz-1]) begin
        mHits[i] = 1'b1;
        mCount++;
        mPos = i;
        mAny = 1'b1;
        histQ.delete();
      end
      while (histQ.size() > 2) void'(histQ.pop_front());
    end
    sz = histQ.size();
    if (sz >= 2 && histQ[sz-2] && histQ[sz-1]) mState = 2;
    else if (sz >= 1 && histQ[sz-1]) mState = 1;
    else mState = 0;
    if (mCount > 15) mCount = 15;
  endtask

  // Called at a negedge. Hands over one word, checks det_hit during the
  // shift phase and the handshake-to-valid latency, returns at the negedge
  // where out_valid is first seen.
  task automatic applyStimulus(input logic [7:0] d, input logic clr);
    int w;
    int lat;
    in_data = d; in_clear = clr; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", int'(in_ready), 1);
    modelWord(d, clr);
    @(negedge clk);
    in_valid = 1'b0; in_clear = 1'b0;
    for (lat = 1; lat < 40; lat++) begin
      if (out_valid) break;
      if (lat <= 8) chk($sformatf("det_hit_bit%0d", 8 - lat), int'(det_hit), int'(mHits[8-lat]));
      @(negedge clk);
    end
    chk("out_valid_rise", int'(out_valid), 1);
    chk("latency", lat, 9);
  endtask

  task automatic checkOutput(input int cnt, input int pos, input logic any, input int st);
    chk("out_valid", int'(out_valid), 1);
    chk("out_count", int'(out_count), cnt);
    chk("out_last_pos", int'(out_last_pos), pos);
    chk("out_any", int'(out_any), int'(any));
    chk("det_state", int'(det_state), st);
    chk("det_hit_report", int'(det_hit), 0);
    chk("sat_count", int'(satOutCount), (cnt > 0) ? 1 : 0);
    chk("sat_last_pos", int'(satOutLastPos), pos);
  endtask

  // Completes the result handshake; returns at the following negedge.
  task automatic drainResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", int'(out_valid), 0);
    chk("in_ready_after_drain", int'(in_ready), 1);
  endtask

  initial begin
    int nWait;
    logic [7:0] rd;
    logic rc;

    vecs[0] = '{8'b1101_1000, 1'b1, 2, 2, 1'b1, 0};
    vecs[1] = '{8'hFF,        1'b1, 0, 0, 1'b0, 2};
    vecs[2] = '{8'b0000_0011, 1'b1, 0, 0, 1'b0, 2};
    vecs[3] = '{8'h00,        1'b0, 1, 7, 1'b1, 0};
    vecs[4] = '{8'b0000_0011, 1'b1, 0, 0, 1'b0, 2};
    vecs[5] = '{8'h00,        1'b1, 0, 0, 1'b0, 0};
    vecs[6] = '{8'b0110_1101, 1'b1, 2, 1, 1'b1, 1};
    vecs[7] = '{8'b1110_1110, 1'b0, 2, 0, 1'b1, 0};

    // Reset values while reset is held low.
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_last_pos", int'(out_last_pos), 0);
    chk("rst_out_any", int'(out_any), 0);
    chk("rst_det_state", int'(det_state), 0);
    chk("rst_det_hit", int'(det_hit), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("in_ready_before_first_edge", int'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_release", int'(in_ready), 1);

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].clr);
      checkOutput(vecs[i].expCount, vecs[i].expPos, vecs[i].expAny, vecs[i].expState);
      drainResult();
    end

    $display("[TB] backpressure");
    applyStimulus(8'b0110_1101, 1'b1);
    checkOutput(2, 1, 1'b1, 1);
    in_data = 8'b1110_1110; in_clear = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      checkOutput(2, 1, 1'b1, 1);
    end
    drainResult();
    applyStimulus(8'b1110_1110, 1'b0);
    checkOutput(2, 0, 1'b1, 0);
    drainResult();

    $display("[TB] reset during shift");
    in_data = 8'b1101_1000; in_clear = 1'b1; in_valid = 1'b1;
    chk("rs_accept_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; in_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rs_count_before", int'(out_count), 1);
    chk("rs_pos_before", int'(out_last_pos), 5);
    reset = 1'b0;
    #1;
    chk("rs_in_ready", int'(in_ready), 0);
    chk("rs_out_valid", int'(out_valid), 0);
    chk("rs_out_count", int'(out_count), 0);
    chk("rs_out_last_pos", int'(out_last_pos), 0);
    chk("rs_out_any", int'(out_any), 0);
    chk("rs_det_state", int'(det_state), 0);
    chk("rs_det_hit", int'(det_hit), 0);
    histQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput(0, 0, 1'b0, 0);
    drainResult();

    $display("[TB] random words");
    for (int n = 0; n < 150; n++) begin
      rd = 8'($urandom);
      rc = ($urandom_range(0, 3) == 0);
      applyStimulus(rd, rc);
      nWait = $urandom_range(0, 3);
      for (int k = 0; k < nWait; k++) @(negedge clk);
      checkOutput(mCount, mPos, mAny, mState);
      if (nWait > 0) chk("rand_bp_in_ready", int'(in_ready), 0);
      drainResult();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
